wash_countdown: RTL and testbench



---
 rtl/wash_countdown_pkg.sv | 38 +++
 rtl/wash_countdown_sec_tick.sv | 41 ++++
 rtl/wash_countdown.sv | 106 ++++++++++
 tb/tb_wash_countdown.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/wash_countdown_pkg.sv
// -----------------------------------------------------------------------------
// wash_countdown_pkg: shared washer constants, state encoding, BCD helper. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package wash_countdown_pkg;

  localparam int TICK_DIV_DEFAULT = 100;
  localparam int BCD_W            = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd2_t;

  // Saturate to 99, then split into two BCD digits with a compare ladder.
  function automatic bcd2_t sat_to_bcd(input logic [6:0] v);
    logic [6:0] s;
    bcd2_t      r;
    s      = (v > 7'd99) ? 7'd99 : v;
    r.tens = '0;
    for (int i = 1; i <= 9; i++) begin
      if (s >= 7'(i * 10)) r.tens = 4'(i);
    end
    r.ones = 4'(s - ({3'b000, r.tens} * 7'd10));
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wash_countdown_sec_tick.sv
// -----------------------------------------------------------------------------
// sec_tick: prescaler with enable/clear; pulses tick_o on its TICK_DIV-1 cycle. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module sec_tick #(
  parameter int TICK_DIV = 100
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          last;

  assign last   = (cnt_q == CW'(TICK_DIV - 1));
  assign tick_o = en_i & last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/wash_countdown.sv
// -----------------------------------------------------------------------------
// wash_countdown: two-digit BCD seconds countdown with load/start/pause and done pulse. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module wash_countdown
  import wash_countdown_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic             qclock,
  input  logic             rst_n,
  input  logic             load,
  input  logic [6:0]       load_val,
  input  logic             start,
  input  logic             pause,
  output logic [BCD_W-1:0] code1,
  output logic [BCD_W-1:0] code2,
  output logic             running,
  output logic             done
);

  state_t           state_q, state_d;
  logic [BCD_W-1:0] tens_q, tens_d;
  logic [BCD_W-1:0] ones_q, ones_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             tick;
  logic             nonzero;
  bcd2_t            ld_bcd;

  sec_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_sec_tick (
    .clk_i  (qclock),
    .rst_ni (rst_n),
    .en_i   (state_q == S_RUN),
    .clr_i  (load),
    .tick_o (tick)
  );

  assign ld_bcd  = sat_to_bcd(load_val);
  assign nonzero = (tens_q != '0) || (ones_q != '0);

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    done_d  = 1'b0;
    if (load) begin
      tens_d  = ld_bcd.tens;
      ones_d  = ld_bcd.ones;
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_PAUSE: begin
          if (start && nonzero) state_d = S_RUN;
        end
        S_RUN: begin
          // A tick on the same edge as pause still counts the elapsed second.
          if (tick) begin
            if (ones_q != '0) begin
              ones_d = ones_q - 1'b1;
            end else begin
              ones_d = 4'd9;
              tens_d = tens_q - 1'b1;
            end
            if (tens_q == '0 && ones_q == 4'd1) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
          if (state_d == S_RUN && !start && pause) state_d = S_PAUSE;
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign running_d = (state_d == S_RUN);

  always_ff @(posedge qclock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tens_q    <= '0;
      ones_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign code1   = tens_q;
  assign code2   = ones_q;
  assign running = running_q;
  assign done    = done_q;

endmodule

`default_nettype wire

// File: tb/tb_wash_countdown.sv
// -----------------------------------------------------------------------------
// tb_wash_countdown: directed scenarios plus random stimulus against a seconds-level model. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_wash_countdown;

  localparam int TD = 4;

  logic       qclock;
  logic       rst_n;
  logic       load;
  logic [6:0] load_val;
  logic       start;
  logic       pause;
  logic [3:0] code1;
  logic [3:0] code2;
  logic       running;
  logic       done;

  int checks   = 0;
  int failures = 0;

  // Reference model: remaining seconds as an integer, cycles elapsed in the current second.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_secs, m_sub, m_mode, m_done;
  int n_done;

  wash_countdown #(.TICK_DIV(TD)) dut (
    .qclock   (qclock),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .code1    (code1),
    .code2    (code2),
    .running  (running),
    .done     (done)
  );

  initial qclock = 1'b0;
  always #5 qclock = ~qclock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_secs = 0; m_sub = 0; m_mode = M_IDLE; m_done = 0;
  endtask

  task automatic model_edge(input int ld, input int lv, input int st, input int pa);
    m_done = 0;
    if (ld != 0) begin
      m_secs = (lv > 99) ? 99 : lv;
      m_sub  = 0;
      m_mode = M_IDLE;
    end else if (m_mode == M_RUN) begin
      m_sub = m_sub + 1;
      if (m_sub == TD) begin
        m_sub  = 0;
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_mode = M_DONE;
          m_done = 1;
        end
      end
      if (m_mode == M_RUN && st == 0 && pa != 0) m_mode = M_PAUSE;
    end else if (m_mode == M_IDLE || m_mode == M_PAUSE) begin
      if (st != 0 && m_secs != 0) m_mode = M_RUN;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".code1"},   int'(code1),   m_secs / 10);
    check({tag, ".code2"},   int'(code2),   m_secs % 10);
    check({tag, ".running"}, int'(running), (m_mode == M_RUN) ? 1 : 0);
    check({tag, ".done"},    int'(done),    m_done);
  endtask

  task automatic drive(input string tag, input logic ld, input logic [6:0] lv,
                       input logic st, input logic pa);
    @(negedge qclock);
    load = ld; load_val = lv; start = st; pause = pa;
    @(posedge qclock);
    model_edge(int'(ld), int'(lv), int'(st), int'(pa));
    #1;
    compare_all(tag);
    if (done) n_done++;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) drive(tag, 1'b0, 7'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int done_at;
    rst_n = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0;
    n_done = 0;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge qclock) rst_n = 1'b1;
    idle("reset_hold", 20);

    // Load 13 and run to completion
    drive("load13", 1'b1, 7'd13, 1'b0, 1'b0);
    check("load13.c1", int'(code1), 1);
    check("load13.c2", int'(code2), 3);
    drive("start13", 1'b0, 7'd0, 1'b1, 1'b0);
    n_done  = 0;
    done_at = -1;
    for (int i = 1; i <= 52; i++) begin
      drive("run13", 1'b0, 7'd0, 1'b0, 1'b0);
      if (i == 4)  check("run13.t4", int'(code1) * 10 + int'(code2), 12);
      if (i == 16) check("run13.borrow", int'(code1) * 10 + int'(code2), 9);
      if (done && done_at < 0) done_at = i;
    end
    check("run13.done_at", done_at, 52);
    idle("done_hold", 10);
    check("run13.done_pulses", n_done, 1);
    check("done_hold.code", int'(code1) * 10 + int'(code2), 0);

    // Saturation and zero load
    drive("load120", 1'b1, 7'd120, 1'b0, 1'b0);
    check("load120.code", int'(code1) * 10 + int'(code2), 99);
    drive("load0", 1'b1, 7'd0, 1'b0, 1'b0);
    n_done = 0;
    drive("start0", 1'b0, 7'd0, 1'b1, 1'b0);
    idle("zero_idle", 6);
    check("zero.running", int'(running), 0);
    check("zero.done_pulses", n_done, 0);

    // Pause / resume keeps the partial second
    drive("load26", 1'b1, 7'd26, 1'b0, 1'b0);
    drive("start26", 1'b0, 7'd0, 1'b1, 1'b0);
    idle("run26", 5);
    drive("pause26", 1'b0, 7'd0, 1'b0, 1'b1);
    check("pause26.code", int'(code1) * 10 + int'(code2), 25);
    idle("paused", 10);
    check("paused.code", int'(code1) * 10 + int'(code2), 25);
    drive("resume26", 1'b0, 7'd0, 1'b1, 1'b0);
    idle("resume26", 1);
    check("resume26.t1", int'(code1) * 10 + int'(code2), 25);
    idle("resume26", 1);
    check("resume26.t2", int'(code1) * 10 + int'(code2), 24);

    // Load colliding with the final terminal tick
    drive("load1", 1'b1, 7'd1, 1'b0, 1'b0);
    drive("start1", 1'b0, 7'd0, 1'b1, 1'b0);
    idle("run1", 3);
    n_done = 0;
    drive("load_on_tick", 1'b1, 7'd57, 1'b0, 1'b0);
    check("load_on_tick.code", int'(code1) * 10 + int'(code2), 57);
    idle("after_load_tick", 3);
    check("load_on_tick.done_pulses", n_done, 0);

    // Asynchronous reset mid-run
    drive("load23", 1'b1, 7'd23, 1'b0, 1'b0);
    drive("start23", 1'b0, 7'd0, 1'b1, 1'b0);
    idle("run23", 2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_reset");
    @(negedge qclock) rst_n = 1'b1;
    n_done = 0;
    idle("post_reset", 8);
    check("post_reset.done_pulses", n_done, 0);

    // Randomized stimulus
    for (int i = 0; i < 600; i++) begin
      logic       r_ld, r_st, r_pa;
      logic [6:0] r_lv;
      r_ld = ($urandom_range(0, 29) == 0);
      r_st = ($urandom_range(0, 7) == 0);
      r_pa = ($urandom_range(0, 9) == 0);
      r_lv = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) r_lv = 7'($urandom_range(0, 3));
      drive("random", r_ld, r_lv, r_st, r_pa);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
